// File: rtl/exception_sequencer.sv
// Pipeline exception/IRQ sequencer: arbitrates step-3 exceptions against masked,
// edge-latched IRQs, flushes the pipeline, vectors to the handler and sequences eret.
module exception_sequencer #(
   parameter int unsigned       N_IRQ       = 4,
   parameter int unsigned       ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] VECTOR_BASE = ADDR_W'(32'h0000_0100)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        cause_in,
   input  logic [ADDR_W-1:0] cause_pc,
   input  logic [N_IRQ-1:0]  irq,
   input  logic              mask_we,
   input  logic [N_IRQ-1:0]  mask_wdata,
   input  logic              eret,
   output logic              interrupts_signal,
   output logic              pc_load,
   output logic [ADDR_W-1:0] pc_vector,
   output logic [ADDR_W-1:0] epc,
   output logic [2:0]        cause_reg,
   output logic [2:0]        irq_id,
   output logic [N_IRQ-1:0]  irq_mask,
   output logic              in_handler
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FLUSH,
      S_VECTOR,
      S_HANDLER,
      S_RETURN
   } state_t;

   localparam logic [2:0] CAUSE_NONE = 3'b100;
   localparam logic [2:0] CAUSE_IRQ  = 3'b010;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   epc_q, epc_d;
   logic [2:0]          cause_q, cause_d;
   logic [2:0]          irq_id_q, irq_id_d;
   logic [N_IRQ-1:0]    mask_q, mask_d;
   logic [N_IRQ-1:0]    pending_q, pending_d;
   logic [N_IRQ-1:0]    irq_q;
   logic                is_irq_q, is_irq_d;

   logic [N_IRQ-1:0]    enabled;
   logic [N_IRQ-1:0]    sel_onehot;
   logic [2:0]          sel_idx;
   logic                found;
   logic                take_irq;
   logic                exc;
   logic [ADDR_W-1:0]   irq_offset;

   assign exc = (cause_in != CAUSE_NONE);

   // Lowest-index enabled pending line.
   always_comb begin
      enabled    = pending_q & mask_q;
      found      = 1'b0;
      sel_idx    = '0;
      sel_onehot = '0;
      for (int unsigned k = 0; k < N_IRQ; k++) begin
         if (enabled[k] && !found) begin
            found         = 1'b1;
            sel_idx       = 3'(k);
            sel_onehot[k] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      epc_d    = epc_q;
      cause_d  = cause_q;
      irq_id_d = irq_id_q;
      is_irq_d = is_irq_q;
      take_irq = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (exc) begin
               cause_d  = cause_in;
               epc_d    = cause_pc;
               is_irq_d = 1'b0;
               state_d  = S_FLUSH;
            end else if (found) begin
               cause_d  = CAUSE_IRQ;
               irq_id_d = sel_idx;
               epc_d    = cause_pc;
               is_irq_d = 1'b1;
               take_irq = 1'b1;
               state_d  = S_FLUSH;
            end
         end
         S_FLUSH:  state_d = S_VECTOR;
         S_VECTOR: state_d = S_HANDLER;
         S_HANDLER: begin
            // Nested exception re-vectors but keeps the original restart PC.
            if (exc) begin
               cause_d  = cause_in;
               is_irq_d = 1'b0;
               state_d  = S_FLUSH;
            end else if (eret) begin
               state_d = S_RETURN;
            end
         end
         S_RETURN: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Rising edges set pending even while a clear is applied the same cycle.
   assign pending_d = (pending_q & ~(sel_onehot & {N_IRQ{take_irq}})) | (irq & ~irq_q);
   assign mask_d    = mask_we ? mask_wdata : mask_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         epc_q     <= '0;
         cause_q   <= CAUSE_NONE;
         irq_id_q  <= '0;
         mask_q    <= '0;
         pending_q <= '0;
         irq_q     <= '0;
         is_irq_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         epc_q     <= epc_d;
         cause_q   <= cause_d;
         irq_id_q  <= irq_id_d;
         mask_q    <= mask_d;
         pending_q <= pending_d;
         irq_q     <= irq;
         is_irq_q  <= is_irq_d;
      end
   end

   assign irq_offset = (ADDR_W'(irq_id_q) + ADDR_W'(1)) << 4;

   always_comb begin
      interrupts_signal = 1'b0;
      pc_load           = 1'b0;
      pc_vector         = '0;
      in_handler        = 1'b0;
      case (state_q)
         S_FLUSH: interrupts_signal = 1'b1;
         S_VECTOR: begin
            pc_load   = 1'b1;
            pc_vector = is_irq_q ? (VECTOR_BASE + irq_offset) : VECTOR_BASE;
         end
         S_HANDLER: in_handler = 1'b1;
         S_RETURN: begin
            interrupts_signal = 1'b1;
            pc_load           = 1'b1;
            pc_vector         = epc_q;
         end
         default: ;
      endcase
   end

   assign epc       = epc_q;
   assign cause_reg = cause_q;
   assign irq_id    = irq_id_q;
   assign irq_mask  = mask_q;

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed table-driven bench for exception_sequencer: one record per clock, outputs
// checked 1 ns after the rising edge, plus hand sequences for nesting, masking and reset.
module tb_exception_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  cause_in;
   logic [31:0] cause_pc;
   logic [3:0]  irq;
   logic        mask_we;
   logic [3:0]  mask_wdata;
   logic        eret;
   logic        interrupts_signal;
   logic        pc_load;
   logic [31:0] pc_vector;
   logic [31:0] epc;
   logic [2:0]  cause_reg;
   logic [2:0]  irq_id;
   logic [3:0]  irq_mask;
   logic        in_handler;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [2:0]  cause;
      logic [31:0] pc;
      logic [3:0]  irq;
      logic        mwe;
      logic [3:0]  mwd;
      logic        eret;
   } in_t;

   typedef struct packed {
      logic        intr;
      logic        pcl;
      logic [31:0] pcv;
      logic [31:0] epc;
      logic [2:0]  cause;
      logic [2:0]  id;
      logic [3:0]  mask;
      logic        inh;
   } out_t;

   typedef struct packed {
      in_t  i;
      out_t o;
   } vec_t;

   vec_t tbl[$];

   exception_sequencer #(
      .N_IRQ      (4),
      .ADDR_W     (32),
      .VECTOR_BASE(32'h0000_0100)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .cause_in         (cause_in),
      .cause_pc         (cause_pc),
      .irq              (irq),
      .mask_we          (mask_we),
      .mask_wdata       (mask_wdata),
      .eret             (eret),
      .interrupts_signal(interrupts_signal),
      .pc_load          (pc_load),
      .pc_vector        (pc_vector),
      .epc              (epc),
      .cause_reg        (cause_reg),
      .irq_id           (irq_id),
      .irq_mask         (irq_mask),
      .in_handler       (in_handler)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [2:0] c, input logic [31:0] pc, input logic [3:0] iq,
                               input logic mwe, input logic [3:0] mwd, input logic er,
                               input logic intr, input logic pcl, input logic [31:0] pcv,
                               input logic [31:0] ep, input logic [2:0] cr, input logic [2:0] id,
                               input logic [3:0] m, input logic inh);
      vec_t v;
      v.i.cause = c;  v.i.pc = pc;   v.i.irq = iq;
      v.i.mwe = mwe;  v.i.mwd = mwd; v.i.eret = er;
      v.o.intr = intr; v.o.pcl = pcl; v.o.pcv = pcv; v.o.epc = ep;
      v.o.cause = cr;  v.o.id = id;   v.o.mask = m;  v.o.inh = inh;
      return v;
   endfunction

   task automatic check(input out_t exp, input string name);
      out_t act;
      act.intr = interrupts_signal; act.pcl = pc_load; act.pcv = pc_vector; act.epc = epc;
      act.cause = cause_reg; act.id = irq_id; act.mask = irq_mask; act.inh = in_handler;
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got intr=%b pcl=%b pcv=%h epc=%h cause=%b id=%0d mask=%b inh=%b, want intr=%b pcl=%b pcv=%h epc=%h cause=%b id=%0d mask=%b inh=%b",
                  name, act.intr, act.pcl, act.pcv, act.epc, act.cause, act.id, act.mask, act.inh,
                  exp.intr, exp.pcl, exp.pcv, exp.epc, exp.cause, exp.id, exp.mask, exp.inh);
      end
   endtask

   task automatic apply(input vec_t v, input string name);
      cause_in = v.i.cause; cause_pc = v.i.pc; irq = v.i.irq;
      mask_we = v.i.mwe; mask_wdata = v.i.mwd; eret = v.i.eret;
      @(posedge clk);
      #1;
      check(v.o, name);
   endtask

   localparam logic [2:0] N = 3'b100;

   initial begin
      reset = 1'b1; cause_in = N; cause_pc = '0; irq = '0;
      mask_we = 1'b0; mask_wdata = '0; eret = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check(mk(N,0,0,0,0,0, 0,0,32'h0,32'h0,3'b100,0,4'h0,0).o, "reset_values");
      reset = 1'b0;

      // syscall from IDLE, handler, eret
      tbl.push_back(mk(3'b011,32'h40,0,0,0,0, 1,0,32'h0,  32'h40,3'b011,0,4'h0,0));
      tbl.push_back(mk(N,0,0,0,0,0,           0,1,32'h100,32'h40,3'b011,0,4'h0,0));
      tbl.push_back(mk(N,0,0,0,0,0,           0,0,32'h0,  32'h40,3'b011,0,4'h0,1));
      tbl.push_back(mk(N,0,0,0,0,1,           1,1,32'h40, 32'h40,3'b011,0,4'h0,0));
      tbl.push_back(mk(N,0,0,0,0,0,           0,0,32'h0,  32'h40,3'b011,0,4'h0,0));
      // mask 0101, lines 2 and 0 rise together
      tbl.push_back(mk(N,0,0,1,4'h5,0,        0,0,32'h0,  32'h40,3'b011,0,4'h5,0));
      tbl.push_back(mk(N,32'h200,4'h5,0,0,0,  0,0,32'h0,  32'h40,3'b011,0,4'h5,0));
      tbl.push_back(mk(N,32'h204,4'h5,0,0,0,  1,0,32'h0,  32'h204,3'b010,0,4'h5,0));
      tbl.push_back(mk(N,0,0,0,0,0,           0,1,32'h110,32'h204,3'b010,0,4'h5,0));
      tbl.push_back(mk(N,0,0,0,0,0,           0,0,32'h0,  32'h204,3'b010,0,4'h5,1));
      tbl.push_back(mk(N,0,0,0,0,1,           1,1,32'h204,32'h204,3'b010,0,4'h5,0));
      tbl.push_back(mk(N,32'h300,0,0,0,0,     0,0,32'h0,  32'h204,3'b010,0,4'h5,0));
      tbl.push_back(mk(N,32'h300,0,0,0,0,     1,0,32'h0,  32'h300,3'b010,2,4'h5,0));
      tbl.push_back(mk(N,0,0,0,0,0,           0,1,32'h130,32'h300,3'b010,2,4'h5,0));
      tbl.push_back(mk(N,0,0,0,0,0,           0,0,32'h0,  32'h300,3'b010,2,4'h5,1));
      tbl.push_back(mk(N,0,0,0,0,1,           1,1,32'h300,32'h300,3'b010,2,4'h5,0));
      tbl.push_back(mk(N,0,0,0,0,0,           0,0,32'h0,  32'h300,3'b010,2,4'h5,0));
      // illegal opcode and enabled irq[1] together: exception first, IRQ after return
      tbl.push_back(mk(N,0,0,1,4'h2,0,        0,0,32'h0,  32'h300,3'b010,2,4'h2,0));
      tbl.push_back(mk(3'b001,32'h500,4'h2,0,0,0, 1,0,32'h0,32'h500,3'b001,2,4'h2,0));
      tbl.push_back(mk(N,0,0,0,0,0,           0,1,32'h100,32'h500,3'b001,2,4'h2,0));
      tbl.push_back(mk(N,0,0,0,0,0,           0,0,32'h0,  32'h500,3'b001,2,4'h2,1));
      tbl.push_back(mk(N,0,0,0,0,1,           1,1,32'h500,32'h500,3'b001,2,4'h2,0));
      tbl.push_back(mk(N,32'h600,0,0,0,0,     0,0,32'h0,  32'h500,3'b001,2,4'h2,0));
      tbl.push_back(mk(N,32'h600,0,0,0,0,     1,0,32'h0,  32'h600,3'b010,1,4'h2,0));
      tbl.push_back(mk(N,0,0,0,0,0,           0,1,32'h120,32'h600,3'b010,1,4'h2,0));
      tbl.push_back(mk(N,0,0,0,0,0,           0,0,32'h0,  32'h600,3'b010,1,4'h2,1));
      tbl.push_back(mk(N,0,0,0,0,1,           1,1,32'h600,32'h600,3'b010,1,4'h2,0));
      tbl.push_back(mk(N,0,0,0,0,0,           0,0,32'h0,  32'h600,3'b010,1,4'h2,0));
      // eret in IDLE is ignored
      tbl.push_back(mk(N,0,0,0,0,1,           0,0,32'h0,  32'h600,3'b010,1,4'h2,0));

      for (int i = 0; i < tbl.size(); i++)
         apply(tbl[i], $sformatf("tbl[%0d]", i));

      // nested exception with simultaneous eret keeps epc
      apply(mk(3'b011,32'h80,0,0,0,0,  1,0,32'h0,  32'h80,3'b011,1,4'h2,0), "nest_enter");
      apply(mk(N,0,0,0,0,0,            0,1,32'h100,32'h80,3'b011,1,4'h2,0), "nest_vec1");
      apply(mk(N,0,0,0,0,0,            0,0,32'h0,  32'h80,3'b011,1,4'h2,1), "nest_hdl1");
      apply(mk(3'b011,32'h999,0,0,0,1, 1,0,32'h0,  32'h80,3'b011,1,4'h2,0), "nest_exc_wins");
      apply(mk(N,0,0,0,0,0,            0,1,32'h100,32'h80,3'b011,1,4'h2,0), "nest_vec2");
      apply(mk(N,0,0,0,0,0,            0,0,32'h0,  32'h80,3'b011,1,4'h2,1), "nest_hdl2");
      apply(mk(N,0,0,0,0,1,            1,1,32'h80, 32'h80,3'b011,1,4'h2,0), "nest_return");
      apply(mk(N,0,0,0,0,0,            0,0,32'h0,  32'h80,3'b011,1,4'h2,0), "nest_idle");

      // masked irq[3] stays pending until the mask enables it
      apply(mk(N,0,0,1,4'h0,0,         0,0,32'h0,  32'h80,3'b011,1,4'h0,0), "mask_clear");
      apply(mk(N,0,4'h8,0,0,0,         0,0,32'h0,  32'h80,3'b011,1,4'h0,0), "masked_rise");
      apply(mk(N,0,4'h8,0,0,0,         0,0,32'h0,  32'h80,3'b011,1,4'h0,0), "masked_hold");
      apply(mk(N,0,0,0,0,0,            0,0,32'h0,  32'h80,3'b011,1,4'h0,0), "masked_fall");
      apply(mk(N,32'h700,0,1,4'h8,0,   0,0,32'h0,  32'h80,3'b011,1,4'h8,0), "mask_write");
      apply(mk(N,32'h700,0,0,0,0,      1,0,32'h0,  32'h700,3'b010,3,4'h8,0), "unmask_flush");
      apply(mk(N,0,0,0,0,0,            0,1,32'h140,32'h700,3'b010,3,4'h8,0), "irq3_vector");
      apply(mk(N,0,0,0,0,0,            0,0,32'h0,  32'h700,3'b010,3,4'h8,1), "irq3_handler");

      // reset asserted while in VECTOR
      apply(mk(3'b101,32'h44,0,0,0,0,  1,0,32'h0,  32'h700,3'b101,3,4'h8,0), "pre_rst_flush");
      apply(mk(N,0,0,0,0,0,            0,1,32'h100,32'h700,3'b101,3,4'h8,0), "pre_rst_vector");
      #2;
      reset = 1'b1;
      #1;
      check(mk(N,0,0,0,0,0, 0,0,32'h0,32'h0,3'b100,0,4'h0,0).o, "async_reset");
      @(posedge clk);
      #1;
      reset = 1'b0;
      apply(mk(N,0,0,0,0,0,            0,0,32'h0,  32'h0,3'b100,0,4'h0,0), "post_reset_idle");
      apply(mk(N,0,0,1,4'hF,0,         0,0,32'h0,  32'h0,3'b100,0,4'hF,0), "post_reset_mask");
      apply(mk(N,0,0,0,0,0,            0,0,32'h0,  32'h0,3'b100,0,4'hF,0), "pending_cleared");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
